// File: rtl/ctrl_pkg.sv
// Shared encodings for the pipelined control unit: opcode/funct values,
// ALUOp and Branch_op codes, and the ID/EX control bundle layout.
package ctrl_pkg;

    localparam logic [5:0] OP_RTYPE  = 6'b000000;
    localparam logic [5:0] OP_REGIMM = 6'b000001;
    localparam logic [5:0] OP_J      = 6'b000010;
    localparam logic [5:0] OP_JAL    = 6'b000011;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_BNE    = 6'b000101;
    localparam logic [5:0] OP_BGTZ   = 6'b000111;
    localparam logic [5:0] OP_ADDI   = 6'b001000;
    localparam logic [5:0] OP_ADDIU  = 6'b001001;
    localparam logic [5:0] OP_SLTI   = 6'b001010;
    localparam logic [5:0] OP_ANDI   = 6'b001100;
    localparam logic [5:0] OP_ORI    = 6'b001101;
    localparam logic [5:0] OP_LUI    = 6'b001111;
    localparam logic [5:0] OP_LW     = 6'b100011;
    localparam logic [5:0] OP_SW     = 6'b101011;

    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_SRA  = 6'b000011;
    localparam logic [5:0] FN_JR   = 6'b001000;
    localparam logic [5:0] FN_MFHI = 6'b010000;
    localparam logic [5:0] FN_MFLO = 6'b010010;
    localparam logic [5:0] FN_MULT = 6'b011000;
    localparam logic [5:0] FN_DIV  = 6'b011010;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SLT  = 6'b101010;

    typedef enum logic [3:0] {
        ALU_NONE = 4'b0000,
        ALU_ADD  = 4'b0001,
        ALU_SUB  = 4'b0010,
        ALU_AND  = 4'b0011,
        ALU_OR   = 4'b0100,
        ALU_NOR  = 4'b0101,
        ALU_SLT  = 4'b0110,
        ALU_SLL  = 4'b0111,
        ALU_SRL  = 4'b1000,
        ALU_SRA  = 4'b1001,
        ALU_ADDU = 4'b1010,
        ALU_SUBU = 4'b1011,
        ALU_MULT = 4'b1100,
        ALU_DIV  = 4'b1101,
        ALU_HILO = 4'b1110,
        ALU_LUI  = 4'b1111
    } alu_op_e;

    typedef enum logic [2:0] {
        BR_NONE = 3'b000,
        BR_BEQ  = 3'b001,
        BR_BNE  = 3'b010,
        BR_BGTZ = 3'b011,
        BR_BGEZ = 3'b100
    } br_op_e;

    typedef struct packed {
        logic    reg_write;
        logic    mem_to_reg;
        logic    mem_read;
        logic    mem_write;
        logic    branch;
        logic    reg_dst;
        logic    alu_src;
        alu_op_e alu_op;
        br_op_e  branch_op;
        logic    hilo_sel;
        logic    is_muldiv;
    } ctrl_bundle_t;

endpackage

// File: rtl/muldiv_busy_ctr.sv
// HI/LO occupancy counter: loaded with the latency when a MULT/DIV bundle
// is registered, counts down to zero. A count of 1 is already "free" so a
// dependent op can issue on the cycle the result lands.
module muldiv_busy_ctr #(
    parameter int unsigned LAT = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic load,
    output logic busy,
    output logic free
);

    localparam int unsigned CW = $clog2(LAT + 1);

    logic [CW-1:0] count;

    // Load on issue, otherwise count down to zero.
    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= CW'(LAT);
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign busy = (count != '0);
    assign free = (count <= CW'(1));

endmodule

// File: rtl/pipe_ctrl_unit.sv
// ID-stage control unit: decodes opcode/funct, registers the control bundle
// into ID/EX, and generates load-use / JR / MULT-DIV stalls, branch flush
// bubbles and illegal-instruction pulses.
module pipe_ctrl_unit
    import ctrl_pkg::*;
#(
    parameter int unsigned ALUOP_W    = 4,
    parameter int unsigned REG_AW     = 5,
    parameter int unsigned MULDIV_LAT = 4,
    parameter int unsigned EN_MULDIV  = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              instr_valid,
    input  logic [5:0]        opcode,
    input  logic [5:0]        funct,
    input  logic [REG_AW-1:0] rs,
    input  logic [REG_AW-1:0] rt,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_mem_read,
    input  logic              ex_reg_write,
    input  logic              flush,
    output logic              stall,
    output logic              ctrl_valid,
    output logic              RegWrite,
    output logic              MemToReg,
    output logic              MemRead,
    output logic              MemWrite,
    output logic              Branch,
    output logic              RegDst,
    output logic              ALUSrc,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic [2:0]        Branch_op,
    output logic              hilo_sel,
    output logic              muldiv_start,
    output logic              muldiv_busy,
    output logic [1:0]        Jump,
    output logic              J_Jump,
    output logic              illegal
);

    ctrl_bundle_t dec;
    ctrl_bundle_t q;
    logic known, is_jr, is_j, is_jal, uses_rt, is_hilo_op;
    logic load_use, jr_haz, md_haz, stall_raw, go, issue, bad, md_free;

    // Instruction decode: bundle plus hazard-relevant attributes.
    always_comb begin
        dec        = '0;
        known      = 1'b0;
        is_jr      = 1'b0;
        is_j       = 1'b0;
        is_jal     = 1'b0;
        uses_rt    = 1'b0;
        is_hilo_op = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                known         = 1'b1;
                uses_rt       = 1'b1;
                dec.reg_write = 1'b1;
                case (funct)
                    FN_ADD:  dec.alu_op = ALU_ADD;
                    FN_ADDU: dec.alu_op = ALU_ADDU;
                    FN_SUB:  dec.alu_op = ALU_SUB;
                    FN_SUBU: dec.alu_op = ALU_SUBU;
                    FN_AND:  dec.alu_op = ALU_AND;
                    FN_OR:   dec.alu_op = ALU_OR;
                    FN_NOR:  dec.alu_op = ALU_NOR;
                    FN_SLT:  dec.alu_op = ALU_SLT;
                    FN_SLL:  dec.alu_op = ALU_SLL;
                    FN_SRL:  dec.alu_op = ALU_SRL;
                    FN_SRA:  dec.alu_op = ALU_SRA;
                    FN_JR: begin
                        dec.reg_write = 1'b0;
                        is_jr         = 1'b1;
                    end
                    FN_MULT, FN_DIV: begin
                        dec.reg_write = 1'b0;
                        dec.alu_op    = (funct == FN_MULT) ? ALU_MULT : ALU_DIV;
                        dec.is_muldiv = 1'b1;
                        is_hilo_op    = 1'b1;
                        known         = (EN_MULDIV != 0);
                    end
                    FN_MFHI, FN_MFLO: begin
                        dec.alu_op   = ALU_HILO;
                        dec.hilo_sel = (funct == FN_MFHI);
                        is_hilo_op   = 1'b1;
                        known        = (EN_MULDIV != 0);
                    end
                    default: known = 1'b0;
                endcase
            end
            OP_ANDI, OP_ORI, OP_SLTI, OP_ADDI, OP_ADDIU, OP_LUI: begin
                known         = 1'b1;
                dec.alu_src   = 1'b1;
                dec.reg_write = 1'b1;
                dec.reg_dst   = 1'b1;
                case (opcode)
                    OP_ANDI:  dec.alu_op = ALU_AND;
                    OP_ORI:   dec.alu_op = ALU_OR;
                    OP_SLTI:  dec.alu_op = ALU_SLT;
                    OP_ADDI:  dec.alu_op = ALU_ADD;
                    OP_ADDIU: dec.alu_op = ALU_ADDU;
                    default:  dec.alu_op = ALU_LUI;
                endcase
            end
            OP_LW: begin
                known          = 1'b1;
                dec.alu_src    = 1'b1;
                dec.reg_write  = 1'b1;
                dec.reg_dst    = 1'b1;
                dec.mem_read   = 1'b1;
                dec.mem_to_reg = 1'b1;
                dec.alu_op     = ALU_ADD;
            end
            OP_SW: begin
                known         = 1'b1;
                uses_rt       = 1'b1;
                dec.alu_src   = 1'b1;
                dec.mem_write = 1'b1;
                dec.alu_op    = ALU_ADD;
            end
            OP_BEQ: begin
                known         = 1'b1;
                uses_rt       = 1'b1;
                dec.branch    = 1'b1;
                dec.branch_op = BR_BEQ;
            end
            OP_BNE: begin
                known         = 1'b1;
                uses_rt       = 1'b1;
                dec.branch    = 1'b1;
                dec.branch_op = BR_BNE;
            end
            OP_BGTZ: begin
                known         = 1'b1;
                dec.branch    = 1'b1;
                dec.branch_op = BR_BGTZ;
            end
            OP_REGIMM: begin
                known         = 1'b1;
                dec.branch    = 1'b1;
                dec.branch_op = BR_BGEZ;
            end
            OP_J: begin
                known = 1'b1;
                is_j  = 1'b1;
            end
            OP_JAL: begin
                known  = 1'b1;
                is_jal = 1'b1;
            end
            default: known = 1'b0;
        endcase
    end

    // Hazard detection and issue qualification; flush overrides any stall.
    always_comb begin
        load_use  = ex_mem_read && (ex_rd != '0) &&
                    ((ex_rd == rs) || ((ex_rd == rt) && uses_rt));
        jr_haz    = is_jr && ex_reg_write && (ex_rd == rs) && (rs != '0);
        md_haz    = is_hilo_op && !md_free;
        stall_raw = instr_valid && (load_use || jr_haz || md_haz);
        go        = !reset && instr_valid && !flush && !stall_raw;
        issue     = go && known;
        bad       = go && !known;
        stall     = !reset && !flush && stall_raw;
        J_Jump    = go && (is_j || is_jal);
        if (go && is_jr) begin
            Jump = 2'b01;
        end else if (go && is_jal) begin
            Jump = 2'b11;
        end else begin
            Jump = 2'b00;
        end
    end

    // ID/EX control register: decoded bundle on issue, bubble otherwise.
    always_ff @(posedge clock) begin
        if (reset) begin
            q          <= '0;
            ctrl_valid <= 1'b0;
            illegal    <= 1'b0;
        end else begin
            q          <= issue ? dec : '0;
            ctrl_valid <= issue;
            illegal    <= bad;
        end
    end

    muldiv_busy_ctr #(.LAT(MULDIV_LAT)) u_busy (
        .clock (clock),
        .reset (reset),
        .load  (issue && dec.is_muldiv),
        .busy  (muldiv_busy),
        .free  (md_free)
    );

    assign RegWrite     = q.reg_write;
    assign MemToReg     = q.mem_to_reg;
    assign MemRead      = q.mem_read;
    assign MemWrite     = q.mem_write;
    assign Branch       = q.branch;
    assign RegDst       = q.reg_dst;
    assign ALUSrc       = q.alu_src;
    assign ALUOp        = ALUOP_W'(q.alu_op);
    assign Branch_op    = q.branch_op;
    assign hilo_sel     = q.hilo_sel;
    assign muldiv_start = q.is_muldiv;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed table-driven bench for pipe_ctrl_unit plus hand sequences for
// reset, MULT/DIV interlock, flush and JR hazard timing.
module tb_pipe_ctrl_unit;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       instr_valid = 1'b0;
    logic [5:0] opcode = '0, funct = '0;
    logic [4:0] rs = '0, rt = '0, ex_rd = '0;
    logic       ex_mem_read = 1'b0, ex_reg_write = 1'b0, flush = 1'b0;
    logic       stall, ctrl_valid, RegWrite, MemToReg, MemRead, MemWrite, Branch, RegDst, ALUSrc;
    logic [3:0] ALUOp;
    logic [2:0] Branch_op;
    logic       hilo_sel, muldiv_start, muldiv_busy, J_Jump, illegal;
    logic [1:0] Jump;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    pipe_ctrl_unit #(.ALUOP_W(4), .REG_AW(5), .MULDIV_LAT(4), .EN_MULDIV(1)) dut (
        .clock(clock), .reset(reset), .instr_valid(instr_valid), .opcode(opcode), .funct(funct),
        .rs(rs), .rt(rt), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write),
        .flush(flush), .stall(stall), .ctrl_valid(ctrl_valid), .RegWrite(RegWrite),
        .MemToReg(MemToReg), .MemRead(MemRead), .MemWrite(MemWrite), .Branch(Branch),
        .RegDst(RegDst), .ALUSrc(ALUSrc), .ALUOp(ALUOp), .Branch_op(Branch_op),
        .hilo_sel(hilo_sel), .muldiv_start(muldiv_start), .muldiv_busy(muldiv_busy),
        .Jump(Jump), .J_Jump(J_Jump), .illegal(illegal)
    );

    typedef struct {
        logic [5:0] op, fn;
        logic [4:0] rs, rt, exrd;
        logic       exmr, exrw, fl, v;
        logic [3:0] comb;   // {stall, Jump, J_Jump}
        logic       cv;
        logic [6:0] flags;  // {RegWrite,MemToReg,MemRead,MemWrite,Branch,RegDst,ALUSrc}
        logic [3:0] alu;
        logic [2:0] br;
        logic       hs, ill;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic [5:0] op, fn, input logic [4:0] r_s, r_t, e_rd,
                                input logic emr, erw, fl, v, input logic [3:0] comb,
                                input logic cv, input logic [6:0] flags, input logic [3:0] alu,
                                input logic [2:0] br, input logic hs, ill);
        vec_t t;
        t.op = op; t.fn = fn; t.rs = r_s; t.rt = r_t; t.exrd = e_rd;
        t.exmr = emr; t.exrw = erw; t.fl = fl; t.v = v; t.comb = comb;
        t.cv = cv; t.flags = flags; t.alu = alu; t.br = br; t.hs = hs; t.ill = ill;
        return t;
    endfunction

    function automatic logic [17:0] reg_word();
        return {ctrl_valid, RegWrite, MemToReg, MemRead, MemWrite, Branch, RegDst, ALUSrc,
                ALUOp, Branch_op, hilo_sel, muldiv_start, illegal};
    endfunction

    function automatic logic [3:0] comb_word();
        return {stall, Jump, J_Jump};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [5:0] op, fn, input logic [4:0] r_s, r_t, e_rd,
                         input logic emr, erw, fl, v);
        @(negedge clock);
        opcode = op; funct = fn; rs = r_s; rt = r_t; ex_rd = e_rd;
        ex_mem_read = emr; ex_reg_write = erw; flush = fl; instr_valid = v;
        #1;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        // R-type ALU ops
        tbl.push_back(mk(6'h00, 6'h20, 1, 2, 0, 0, 0, 0, 1, 4'b0000, 1, 7'b1000000, 4'b0001, 3'b000, 0, 0));
        tbl.push_back(mk(6'h00, 6'h21, 1, 2, 0, 0, 0, 0, 1, 4'b0000, 1, 7'b1000000, 4'b1010, 3'b000, 0, 0));
        tbl.push_back(mk(6'h00, 6'h22, 1, 2, 0, 0, 0, 0, 1, 4'b0000, 1, 7'b1000000, 4'b0010, 3'b000, 0, 0));
        tbl.push_back(mk(6'h00, 6'h23, 1, 2, 0, 0, 0, 0, 1, 4'b0000, 1, 7'b1000000, 4'b1011, 3'b000, 0, 0));
        tbl.push_back(mk(6'h00, 6'h24, 1, 2, 0, 0, 0, 0, 1, 4'b0000, 1, 7'b1000000, 4'b0011, 3'b000, 0, 0));
        tbl.push_back(mk(6'h00, 6'h25, 1, 2, 0, 0, 0, 0, 1, 4'b0000, 1, 7'b1000000, 4'b0100, 3'b000, 0, 0));
        tbl.push_back(mk(6'h00, 6'h27, 1, 2, 0, 0, 0, 0, 1, 4'b0000, 1, 7'b1000000, 4'b0101, 3'b000, 0, 0));
        tbl.push_back(mk(6'h00, 6'h2A, 1, 2, 0, 0, 0, 0, 1, 4'b0000, 1, 7'b1000000, 4'b0110, 3'b000, 0, 0));
        tbl.push_back(mk(6'h00, 6'h00, 0, 0, 0, 0, 0, 0, 1, 4'b0000, 1, 7'b1000000, 4'b0111, 3'b000, 0, 0));
        tbl.push_back(mk(6'h00, 6'h02, 1, 2, 0, 0, 0, 0, 1, 4'b0000, 1, 7'b1000000, 4'b1000, 3'b000, 0, 0));
        tbl.push_back(mk(6'h00, 6'h03, 1, 2, 0, 0, 0, 0, 1, 4'b0000, 1, 7'b1000000, 4'b1001, 3'b000, 0, 0));
        // I-type ALU ops
        tbl.push_back(mk(6'h0C, 6'h00, 1, 2, 0, 0, 0, 0, 1, 4'b0000, 1, 7'b1000011, 4'b0011, 3'b000, 0, 0));
        tbl.push_back(mk(6'h0D, 6'h00, 1, 2, 0, 0, 0, 0, 1, 4'b0000, 1, 7'b1000011, 4'b0100, 3'b000, 0, 0));
        tbl.push_back(mk(6'h0A, 6'h00, 1, 2, 0, 0, 0, 0, 1, 4'b0000, 1, 7'b1000011, 4'b0110, 3'b000, 0, 0));
        tbl.push_back(mk(6'h08, 6'h00, 1, 2, 0, 0, 0, 0, 1, 4'b0000, 1, 7'b1000011, 4'b0001, 3'b000, 0, 0));
        tbl.push_back(mk(6'h09, 6'h00, 1, 2, 0, 0, 0, 0, 1, 4'b0000, 1, 7'b1000011, 4'b1010, 3'b000, 0, 0));
        tbl.push_back(mk(6'h0F, 6'h00, 1, 2, 0, 0, 0, 0, 1, 4'b0000, 1, 7'b1000011, 4'b1111, 3'b000, 0, 0));
        // memory
        tbl.push_back(mk(6'h23, 6'h00, 1, 2, 0, 0, 0, 0, 1, 4'b0000, 1, 7'b1110011, 4'b0001, 3'b000, 0, 0));
        tbl.push_back(mk(6'h2B, 6'h00, 1, 2, 0, 0, 0, 0, 1, 4'b0000, 1, 7'b0001001, 4'b0001, 3'b000, 0, 0));
        // branches
        tbl.push_back(mk(6'h04, 6'h00, 1, 2, 0, 0, 0, 0, 1, 4'b0000, 1, 7'b0000100, 4'b0000, 3'b001, 0, 0));
        tbl.push_back(mk(6'h05, 6'h00, 1, 2, 0, 0, 0, 0, 1, 4'b0000, 1, 7'b0000100, 4'b0000, 3'b010, 0, 0));
        tbl.push_back(mk(6'h07, 6'h00, 1, 2, 0, 0, 0, 0, 1, 4'b0000, 1, 7'b0000100, 4'b0000, 3'b011, 0, 0));
        tbl.push_back(mk(6'h01, 6'h00, 1, 2, 0, 0, 0, 0, 1, 4'b0000, 1, 7'b0000100, 4'b0000, 3'b100, 0, 0));
        // mfhi / mflo with nothing pending
        tbl.push_back(mk(6'h00, 6'h10, 0, 0, 0, 0, 0, 0, 1, 4'b0000, 1, 7'b1000000, 4'b1110, 3'b000, 1, 0));
        tbl.push_back(mk(6'h00, 6'h12, 0, 0, 0, 0, 0, 0, 1, 4'b0000, 1, 7'b1000000, 4'b1110, 3'b000, 0, 0));
        // jumps
        tbl.push_back(mk(6'h02, 6'h00, 0, 0, 0, 0, 0, 0, 1, 4'b0001, 1, 7'b0000000, 4'b0000, 3'b000, 0, 0));
        tbl.push_back(mk(6'h03, 6'h00, 0, 0, 0, 0, 0, 0, 1, 4'b0111, 1, 7'b0000000, 4'b0000, 3'b000, 0, 0));
        tbl.push_back(mk(6'h00, 6'h08, 5, 0, 0, 0, 0, 0, 1, 4'b0010, 1, 7'b0000000, 4'b0000, 3'b000, 0, 0));
        tbl.push_back(mk(6'h00, 6'h08, 0, 0, 0, 0, 1, 0, 1, 4'b0010, 1, 7'b0000000, 4'b0000, 3'b000, 0, 0));
        // illegal opcode / funct, invalid slot
        tbl.push_back(mk(6'h3F, 6'h00, 0, 0, 0, 0, 0, 0, 1, 4'b0000, 0, 7'b0000000, 4'b0000, 3'b000, 0, 1));
        tbl.push_back(mk(6'h00, 6'h3F, 0, 0, 0, 0, 0, 0, 1, 4'b0000, 0, 7'b0000000, 4'b0000, 3'b000, 0, 1));
        tbl.push_back(mk(6'h00, 6'h20, 1, 2, 0, 0, 0, 0, 0, 4'b0000, 0, 7'b0000000, 4'b0000, 3'b000, 0, 0));
        // load-use
        tbl.push_back(mk(6'h00, 6'h20, 8, 2, 8, 1, 1, 0, 1, 4'b1000, 0, 7'b0000000, 4'b0000, 3'b000, 0, 0));
        tbl.push_back(mk(6'h00, 6'h20, 0, 2, 0, 1, 1, 0, 1, 4'b0000, 1, 7'b1000000, 4'b0001, 3'b000, 0, 0));
        tbl.push_back(mk(6'h00, 6'h20, 1, 9, 9, 1, 1, 0, 1, 4'b1000, 0, 7'b0000000, 4'b0000, 3'b000, 0, 0));
        tbl.push_back(mk(6'h08, 6'h00, 1, 9, 9, 1, 1, 0, 1, 4'b0000, 1, 7'b1000011, 4'b0001, 3'b000, 0, 0));
        tbl.push_back(mk(6'h2B, 6'h00, 1, 9, 9, 1, 1, 0, 1, 4'b1000, 0, 7'b0000000, 4'b0000, 3'b000, 0, 0));
        tbl.push_back(mk(6'h00, 6'h20, 8, 2, 8, 0, 1, 0, 1, 4'b0000, 1, 7'b1000000, 4'b0001, 3'b000, 0, 0));
        // flush beats decode, stall and illegal
        tbl.push_back(mk(6'h00, 6'h20, 1, 2, 0, 0, 0, 1, 1, 4'b0000, 0, 7'b0000000, 4'b0000, 3'b000, 0, 0));
        tbl.push_back(mk(6'h04, 6'h00, 8, 2, 8, 1, 1, 1, 1, 4'b0000, 0, 7'b0000000, 4'b0000, 3'b000, 0, 0));
        tbl.push_back(mk(6'h3F, 6'h00, 0, 0, 0, 0, 0, 1, 1, 4'b0000, 0, 7'b0000000, 4'b0000, 3'b000, 0, 0));
        tbl.push_back(mk(6'h02, 6'h00, 0, 0, 0, 0, 0, 1, 1, 4'b0000, 0, 7'b0000000, 4'b0000, 3'b000, 0, 0));
        // JR hazard
        tbl.push_back(mk(6'h00, 6'h08, 31, 0, 31, 0, 1, 0, 1, 4'b1000, 0, 7'b0000000, 4'b0000, 3'b000, 0, 0));

        // Reset state, with a jal presented so comb outputs would otherwise be live
        drive(6'h03, 6'h00, 0, 0, 0, 0, 0, 0, 1);
        check("reset_comb", comb_word(), 4'b0000);
        tick();
        tick();
        check("reset_bundle", reg_word(), 18'd0);
        check("reset_busy", muldiv_busy, 1'b0);
        reset = 1'b0;

        foreach (tbl[i]) begin
            drive(tbl[i].op, tbl[i].fn, tbl[i].rs, tbl[i].rt, tbl[i].exrd,
                  tbl[i].exmr, tbl[i].exrw, tbl[i].fl, tbl[i].v);
            check($sformatf("vec%0d_comb", i), comb_word(), tbl[i].comb);
            tick();
            check($sformatf("vec%0d_bundle", i), reg_word(),
                  {tbl[i].cv, tbl[i].flags, tbl[i].alu, tbl[i].br, tbl[i].hs, 1'b0, tbl[i].ill});
        end

        // mult followed by back-to-back mflo
        drive(6'h00, 6'h18, 1, 2, 0, 0, 0, 0, 1);
        check("mult_stall", stall, 1'b0);
        tick();
        check("mult_bundle", {ctrl_valid, muldiv_start, muldiv_busy, RegWrite, ALUOp}, 8'b1110_1100);
        for (int k = 0; k < 3; k++) begin
            drive(6'h00, 6'h12, 0, 0, 0, 0, 0, 0, 1);
            check($sformatf("mflo_wait%0d_stall", k), stall, 1'b1);
            tick();
            check($sformatf("mflo_wait%0d_bundle", k), {ctrl_valid, muldiv_start, muldiv_busy}, 3'b001);
        end
        drive(6'h00, 6'h12, 0, 0, 0, 0, 0, 0, 1);
        check("mflo_issue_stall", stall, 1'b0);
        check("mflo_issue_busy", muldiv_busy, 1'b1);
        tick();
        check("mflo_bundle", {ctrl_valid, RegWrite, ALUOp, hilo_sel, muldiv_busy}, 8'b11_1110_00);

        // Busy: other ops proceed, flush keeps count, reissue at count 1
        drive(6'h00, 6'h1A, 1, 2, 0, 0, 0, 0, 1);
        tick();
        check("div_start", {muldiv_start, ALUOp}, 5'b1_1101);
        drive(6'h00, 6'h20, 1, 2, 0, 0, 0, 0, 1);
        check("add_busy_stall", stall, 1'b0);
        tick();
        check("add_busy_bundle", {ctrl_valid, ALUOp, muldiv_start, muldiv_busy}, 7'b1_0001_01);
        drive(6'h00, 6'h18, 1, 2, 0, 0, 0, 1, 1);
        check("flush_mult_stall", stall, 1'b0);
        tick();
        check("flush_mult_bundle", {ctrl_valid, muldiv_start, muldiv_busy}, 3'b001);
        drive(6'h00, 6'h20, 1, 2, 0, 0, 0, 0, 0);
        tick();
        drive(6'h00, 6'h18, 1, 2, 0, 0, 0, 0, 1);
        check("mult_at_one_stall", stall, 1'b0);
        tick();
        check("mult_at_one_bundle", {ctrl_valid, muldiv_start, muldiv_busy}, 3'b111);
        drive(6'h00, 6'h20, 1, 2, 0, 0, 0, 0, 0);
        tick();
        check("start_pulse", muldiv_start, 1'b0);
        tick();
        tick();
        check("busy_last", muldiv_busy, 1'b1);
        tick();
        check("busy_clear", muldiv_busy, 1'b0);

        // Mid-stream reset clears the busy counter
        drive(6'h00, 6'h18, 1, 2, 0, 0, 0, 0, 1);
        tick();
        reset = 1'b1;
        drive(6'h03, 6'h00, 0, 0, 0, 0, 0, 0, 1);
        check("midreset_comb", comb_word(), 4'b0000);
        tick();
        check("midreset_bundle1", {reg_word(), muldiv_busy}, 19'd0);
        tick();
        check("midreset_bundle2", {reg_word(), muldiv_busy}, 19'd0);
        reset = 1'b0;
        drive(6'h00, 6'h10, 0, 0, 0, 0, 0, 0, 1);
        check("post_reset_mfhi_stall", stall, 1'b0);
        tick();
        check("post_reset_mfhi", {ctrl_valid, ALUOp, hilo_sel}, 6'b1_1110_1);

        // JR hazard then release
        drive(6'h00, 6'h08, 31, 0, 31, 0, 1, 0, 1);
        check("jr_haz_comb", comb_word(), 4'b1000);
        tick();
        check("jr_haz_bundle", ctrl_valid, 1'b0);
        drive(6'h00, 6'h08, 31, 0, 31, 0, 0, 0, 1);
        check("jr_go_comb", comb_word(), 4'b0010);
        tick();
        check("jr_go_bundle", {ctrl_valid, illegal}, 2'b10);

        // Illegal is a single-cycle pulse
        drive(6'h3F, 6'h00, 0, 0, 0, 0, 0, 0, 1);
        tick();
        check("illegal_pulse", {illegal, ctrl_valid}, 2'b10);
        drive(6'h00, 6'h20, 1, 2, 0, 0, 0, 0, 1);
        tick();
        check("illegal_clear", {illegal, ctrl_valid}, 2'b01);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
